mdu_seq: RTL

- Sequencer for the multi-cycle multiply/divide resources used by the execute stage.
- Accepts one MDU operation at a time: DIV/DIVU, or MADD/MADDU/MSUB/MSUBU.
- Owns the divider start/ready handshake and the two-step HI/LO accumulate. Raises the execute-stage stall request, and returns a 64-bit {HI,LO} result for the HI/LO write path.
- Replaces the ad-hoc cnt/hilo_temp loop that runs through the EX/MEM register.

---
 rtl/mdu_seq_pkg.sv | 37 +++
 rtl/mdu_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared op codes, state codes and decode helpers for the MDU sequencer

package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_DIV   = 3'd1,
        MDU_DIVU  = 3'd2,
        MDU_MADD  = 3'd3,
        MDU_MADDU = 3'd4,
        MDU_MSUB  = 3'd5,
        MDU_MSUBU = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE     = 2'd0,
        MDU_DIV_WAIT = 2'd1,
        MDU_ACC      = 2'd2,
        MDU_DONE     = 2'd3
    } mdu_state_e;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequencer for divide and HI/LO multiply-accumulate ops in the execute stage

module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [2*WIDTH-1:0]   prod_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 advance_i,
    input  logic                 annul_i,
    output logic                 div_start_o,
    output logic                 div_signed_o,
    output logic [WIDTH-1:0]     div_opdata1_o,
    output logic [WIDTH-1:0]     div_opdata2_o,
    output logic                 div_annul_o,
    input  logic                 div_ready_i,
    input  logic [2*WIDTH-1:0]   div_result_i,
    output logic                 stallreq_o,
    output logic                 res_valid_o,
    output logic [WIDTH-1:0]     hi_o,
    output logic [WIDTH-1:0]     lo_o,
    output logic                 timeout_o
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    mdu_state_e           state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opa_r;
    logic [WIDTH-1:0]     opb_r;
    logic                 signed_r;
    logic [2*WIDTH-1:0]   acc_tmp;
    logic [2*WIDTH-1:0]   result;

    logic abort;
    logic accept_div;
    logic accept_acc;
    logic tmo_hit;

    // Losing op_valid while stalled means the instruction left the stage: same as a flush.
    assign abort      = annul_i || (((state == MDU_DIV_WAIT) || (state == MDU_ACC)) && !op_valid_i);
    assign accept_div = (state == MDU_IDLE) && op_valid_i && !annul_i && is_div(op_i);
    assign accept_acc = (state == MDU_IDLE) && op_valid_i && !annul_i && is_acc(op_i);
    assign tmo_hit    = (state == MDU_DIV_WAIT) && !abort && !div_ready_i
                        && (cnt == CW'(DIV_TIMEOUT - 1));

    always_comb begin
        stallreq_o    = NO_STOP;
        div_start_o   = 1'b0;
        div_signed_o  = 1'b0;
        div_opdata1_o = '0;
        div_opdata2_o = '0;
        div_annul_o   = 1'b0;
        res_valid_o   = 1'b0;
        hi_o          = '0;
        lo_o          = '0;
        case (state)
            MDU_IDLE: begin
                stallreq_o = (accept_div || accept_acc) ? STOP : NO_STOP;
            end
            MDU_DIV_WAIT: begin
                stallreq_o    = abort ? NO_STOP : STOP;
                div_start_o   = 1'b1;
                div_signed_o  = signed_r;
                div_opdata1_o = opa_r;
                div_opdata2_o = opb_r;
                div_annul_o   = abort || tmo_hit;
            end
            MDU_ACC: begin
                stallreq_o = abort ? NO_STOP : STOP;
            end
            MDU_DONE: begin
                res_valid_o = !annul_i;
                if (!annul_i) begin
                    hi_o = result[2*WIDTH-1:WIDTH];
                    lo_o = result[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            opa_r     <= '0;
            opb_r     <= '0;
            signed_r  <= 1'b0;
            acc_tmp   <= '0;
            result    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (accept_div) begin
                        opa_r    <= opa_i;
                        opb_r    <= opb_i;
                        signed_r <= (op_i == MDU_DIV);
                        cnt      <= '0;
                        state    <= MDU_DIV_WAIT;
                    end else if (accept_acc) begin
                        acc_tmp <= is_sub(op_i) ? -prod_i : prod_i;
                        state   <= MDU_ACC;
                    end
                end
                MDU_DIV_WAIT: begin
                    if (abort) begin
                        state <= MDU_IDLE;
                    end else if (div_ready_i) begin
                        result <= div_result_i;
                        state  <= MDU_DONE;
                    end else if (tmo_hit) begin
                        result    <= '0;
                        timeout_o <= 1'b1;
                        state     <= MDU_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MDU_ACC: begin
                    // hilo_i is taken here rather than at issue so forwarding has settled.
                    if (abort) begin
                        state <= MDU_IDLE;
                    end else begin
                        result <= acc_tmp + hilo_i;
                        state  <= MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    if (annul_i || advance_i) state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule
